// File: rtl/top_buf_core.sv
// First-word-fall-through buffer with valid/ready handshakes on both sides,
// fill-level / almost-full / sticky overflow status and a synchronous flush.
module top_buf_core #(
  parameter int unsigned width_p = 10,
  parameter int unsigned depth_p = 4,
  parameter int unsigned afull_p = 3,
  localparam int unsigned lvl_w  = $clog2(depth_p + 1)
) (
  input  logic               main_clk_i,
  input  logic               main_rst_an_i,
  input  logic [width_p-1:0] in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [width_p-1:0] out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  input  logic               clr_i,
  output logic [lvl_w-1:0]   level_o,
  output logic               afull_o,
  output logic               ovf_o
);

  localparam int unsigned ptr_w = $clog2(depth_p);
  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(depth_p - 1);

  logic [width_p-1:0] mem_q [depth_p];
  logic [ptr_w-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ptr_w-1:0]   wr_ptr_nxt, rd_ptr_nxt;
  logic [lvl_w-1:0]   level_q;
  logic               ovf_q;
  logic               push, pop, ovf_set;

  // Flags decode only the registered level, so no input reaches an output.
  always_comb begin
    in_ready_o  = (level_q != lvl_w'(depth_p));
    out_valid_o = (level_q != '0);
    afull_o     = (level_q >= lvl_w'(afull_p));
    level_o     = level_q;
    ovf_o       = ovf_q;
    out_data_o  = mem_q[rd_ptr_q];
  end

  always_comb begin
    push       = in_valid_i & in_ready_o;
    pop        = out_valid_o & out_ready_i;
    ovf_set    = in_valid_i & ~in_ready_o;
    // Explicit wrap keeps non-power-of-two depths working.
    wr_ptr_nxt = (wr_ptr_q == last_ptr) ? '0 : wr_ptr_q + ptr_w'(1);
    rd_ptr_nxt = (rd_ptr_q == last_ptr) ? '0 : rd_ptr_q + ptr_w'(1);
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < int'(depth_p); i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_i) begin
      // Flush wins over push, pop and overflow; storage is left as is.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= wr_ptr_nxt;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_nxt;
      end
      if (push && !pop) begin
        level_q <= level_q + lvl_w'(1);
      end else if (pop && !push) begin
        level_q <= level_q - lvl_w'(1);
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_top_buf_core.sv
// Directed bench for top_buf_core: default depth 4 instance plus a depth 5
// instance for the non-power-of-two wrap and almost-full threshold.
module tb_top_buf_core;

  logic       clk;
  logic       rst_n;

  logic [9:0] a_in_data, a_out_data;
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_clr;
  logic [2:0] a_level;
  logic       a_afull, a_ovf;

  logic [9:0] b_in_data, b_out_data;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_clr;
  logic [2:0] b_level;
  logic       b_afull, b_ovf;

  int passes = 0;
  int total  = 0;

  top_buf_core u_dut (
    .main_clk_i    (clk),
    .main_rst_an_i (rst_n),
    .in_data_i     (a_in_data),
    .in_valid_i    (a_in_valid),
    .in_ready_o    (a_in_ready),
    .out_data_o    (a_out_data),
    .out_valid_o   (a_out_valid),
    .out_ready_i   (a_out_ready),
    .clr_i         (a_clr),
    .level_o       (a_level),
    .afull_o       (a_afull),
    .ovf_o         (a_ovf)
  );

  top_buf_core #(
    .width_p (10),
    .depth_p (5),
    .afull_p (4)
  ) u_dut5 (
    .main_clk_i    (clk),
    .main_rst_an_i (rst_n),
    .in_data_i     (b_in_data),
    .in_valid_i    (b_in_valid),
    .in_ready_o    (b_in_ready),
    .out_data_o    (b_out_data),
    .out_valid_o   (b_out_valid),
    .out_ready_i   (b_out_ready),
    .clr_i         (b_clr),
    .level_o       (b_level),
    .afull_o       (b_afull),
    .ovf_o         (b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    a_in_data   = '0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    a_clr       = 1'b0;
    b_in_data   = '0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    b_clr       = 1'b0;

    #12;
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_level", a_level, 0);
    check("rst_afull", a_afull, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_out_data", a_out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single word: visible one edge after the push.
    a_in_data  = 10'h155;
    a_in_valid = 1'b1;
    check("nobypass_valid", a_out_valid, 0);
    step();
    a_in_valid = 1'b0;
    check("one_valid", a_out_valid, 1);
    check("one_data", a_out_data, 10'h155);
    check("one_level", a_level, 1);
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    check("one_pop_level", a_level, 0);
    check("one_pop_valid", a_out_valid, 0);

    // Fill to full.
    for (int i = 1; i <= 4; i++) begin
      a_in_data  = 10'(i);
      a_in_valid = 1'b1;
      step();
      check("fill_level", a_level, i);
      check("fill_afull", a_afull, (i >= 3) ? 1 : 0);
      check("fill_in_ready", a_in_ready, (i < 4) ? 1 : 0);
    end
    a_in_valid = 1'b0;

    // Drain in order.
    a_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_data", a_out_data, i);
      step();
    end
    a_out_ready = 1'b0;
    check("drain_level", a_level, 0);
    check("drain_valid", a_out_valid, 0);
    check("empty_pop_ignored_ovf", a_ovf, 0);

    // Streaming at level 2.
    a_in_valid = 1'b1;
    a_in_data  = 10'h010;
    step();
    a_in_data  = 10'h011;
    step();
    a_out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      a_in_data = 10'(10'h012 + k);
      check("stream_data", a_out_data, 10'h010 + k);
      step();
      check("stream_level", a_level, 2);
    end
    a_out_ready = 1'b0;
    a_in_data   = 10'h026;
    step();
    a_in_data   = 10'h027;
    step();
    check("full_level", a_level, 4);
    check("full_in_ready", a_in_ready, 0);

    // Overflow: word dropped, flag sticky.
    a_in_data = 10'h3FF;
    step();
    a_in_valid = 1'b0;
    check("ovf_set", a_ovf, 1);
    check("ovf_level", a_level, 4);
    check("ovf_head", a_out_data, 10'h024);
    step();
    check("ovf_sticky", a_ovf, 1);

    // Full with simultaneous pop: push still refused.
    a_in_valid  = 1'b1;
    a_in_data   = 10'h3FF;
    a_out_ready = 1'b1;
    step();
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    check("fullpop_level", a_level, 3);
    check("fullpop_in_ready", a_in_ready, 1);
    check("fullpop_head", a_out_data, 10'h025);

    // Flush beats a concurrent push.
    a_clr      = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = 10'h123;
    step();
    a_clr      = 1'b0;
    a_in_valid = 1'b0;
    check("clr_level", a_level, 0);
    check("clr_ovf", a_ovf, 0);
    check("clr_valid", a_out_valid, 0);

    // Async reset mid-operation.
    a_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_data = 10'(10'h031 + i);
      step();
    end
    a_in_valid = 1'b0;
    check("prerst_level", a_level, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_level", a_level, 0);
    check("arst_valid", a_out_valid, 0);
    check("arst_in_ready", a_in_ready, 1);
    check("arst_data", a_out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = 10'h0AA;
    step();
    a_in_valid = 1'b0;
    check("postrst_data", a_out_data, 10'h0AA);
    check("postrst_level", a_level, 1);

    // Depth 5, afull 4: 12 pushes across a non-power-of-two wrap.
    b_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_in_data = 10'(10'h050 + i);
      step();
      check("d5_fill_level", b_level, i + 1);
      check("d5_fill_afull", b_afull, (i + 1 >= 4) ? 1 : 0);
    end
    b_in_valid = 1'b0;
    check("d5_full_in_ready", b_in_ready, 0);
    b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("d5_pop_data", b_out_data, 10'h050 + i);
      step();
      check("d5_pop_afull", b_afull, (4 - i >= 4) ? 1 : 0);
    end
    check("d5_mid_level", b_level, 2);
    b_in_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      b_in_data = 10'(10'h055 + k);
      check("d5_stream_data", b_out_data, 10'h053 + k);
      step();
      check("d5_stream_level", b_level, 2);
    end
    b_in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("d5_tail_data", b_out_data, 10'h05A + k);
      step();
    end
    b_out_ready = 1'b0;
    check("d5_end_level", b_level, 0);
    check("d5_end_valid", b_out_valid, 0);
    check("d5_ovf", b_ovf, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/top_buf_core.md
Name: top_buf_core

Overview:
Parametrised successor to the plain data core. It adds a depth_p-entry first-word-fall-through buffer between the main data input and output, with valid/ready handshakes on both sides. It also provides fill-level, almost-full and sticky overflow status, and a synchronous flush. It sits in the top-level data path on the main clock domain, between the upstream data source and the downstream consumer.

Parameters:
width_p, 10, data word width in bits (>=1)
depth_p, 4, number of buffer entries (>=2; non-power-of-two supported)
afull_p, 3, almost-full threshold in entries (1..depth_p); default equals depth_p-1 for the default depth
lvl_w (local), $clog2(depth_p+1), width of the level output

Ports:
main_clk_i  input  1  main clock, rising edge
main_rst_an_i  input  1  async reset, active-low
in_data_i  input  width_p  write data
in_valid_i  input  1  write request
in_ready_o  output  1  buffer can accept a word (not full)
out_data_o  output  width_p  head-of-buffer data
out_valid_o  output  1  head data valid (not empty)
out_ready_i  input  1  consumer takes the head word
clr_i  input  1  synchronous flush; also clears the overflow flag
level_o  output  lvl_w  number of stored entries, 0..depth_p
afull_o  output  1  level_o >= afull_p
ovf_o  output  1  sticky: a write was attempted while full

Behaviour:
- Reset: the single clock is main_clk_i. Reset is main_rst_an_i, asynchronous and active-low.
  - Asserting reset immediately clears the pointers, level and ovf_o.
  - Outputs during and after reset: in_ready_o=1, out_valid_o=0, level_o=0, afull_o=0 (afull_p>=1), ovf_o=0, out_data_o=0. Storage is also cleared to 0.
  - Deassertion is assumed synchronous to main_clk_i (synchroniser lives upstream).
- Push: occurs when in_valid_i & in_ready_o at a rising edge. The word is written to mem[wr_ptr] and wr_ptr advances.
- Pop: occurs when out_valid_o & out_ready_i at a rising edge. rd_ptr advances.
- Pointer wrap: both pointers count 0..depth_p-1 and wrap to 0. No power-of-two assumption.
- Head data: out_data_o = mem[rd_ptr], driven combinationally from registers.
  - When empty, out_data_o holds the last stored value at rd_ptr. Content is don't-care but must not be X after reset.
- Latency: a word pushed at edge N appears on out_data_o with out_valid_o=1 after edge N, one cycle in an empty buffer. There is no combinational in-to-out bypass.
- Flags: in_ready_o = (level != depth_p); out_valid_o = (level != 0); afull_o = (level >= afull_p). All are decoded from registered level, with no input-to-output combinational path.
- Level update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged, both pointers advance
- Full: in_ready_o=0, so no push is accepted even if a pop happens the same cycle. After that pop the level is depth_p-1 and in_ready_o=1 in the next cycle.
- Empty: out_valid_o=0, so out_ready_i is ignored and level never underflows.
- Overflow: in_valid_i=1 while in_ready_o=0 at an edge sets ovf_o=1 at that edge. The word is dropped and the stored data is unchanged. ovf_o stays set until clr_i or reset.
- Flush: clr_i=1 at an edge clears wr_ptr, rd_ptr, level and ovf_o.
  - It has priority over a push, a pop and overflow detection in the same cycle; a concurrent push is discarded.
  - Storage contents are not cleared.
- Reset mid-operation: all state clears immediately and in-flight words are lost. After reset, the first push lands in entry 0.

Test Plan:
- Reset then idle: in_ready_o=1, out_valid_o=0, level_o=0, ovf_o=0. Push 0x155 -> one edge later out_valid_o=1, out_data_o=0x155, level_o=1.
- Fill with 0x001..0x004, out_ready_i=0 (depth_p=4) -> level_o=4, in_ready_o=0, afull_o=1 from level 3 on. Then drain with out_ready_i=1 -> outputs 0x001,0x002,0x003,0x004 in order, level 0.
- Streaming at level 2 with push and pop every cycle for 20 cycles, data counting up -> level_o stays 2, output sequence in order, pointers wrap cleanly.
- Full buffer, hold in_valid_i=1 with 0x3FF for one cycle -> ovf_o=1 and stays 1, 0x3FF never appears at the output. Then clr_i=1 -> level_o=0, ovf_o=0, out_valid_o=0.
- depth_p=5, afull_p=4: 12 pushes interleaved with pops -> correct order across non-power-of-two wrap, afull_o asserted exactly when level_o>=4.
- Level 3, then assert main_rst_an_i=0 asynchronously between edges -> outputs reset immediately with no clock. After release, push 0x0AA -> out_data_o=0x0AA.
